mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring, on magnitudes)
// producing HI/LO results. One iteration per cycle, 32 iterations per operation.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] quo_q, quo_d;
  logic        q1_q, q1_d;
  logic [31:0] opm_q, opm_d;
  logic        negQuot_q, negQuot_d;
  logic        negRem_q, negRem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        divZero_q, divZero_d;

  logic [32:0] boothSum;
  logic [31:0] boothAcc, boothQuo;
  logic [31:0] remShift;
  logic [32:0] remDiff;
  logic        divOk;
  logic [31:0] divAcc, divQuo;
  logic [31:0] absA, absB;
  logic [5:0]  cntNext;
  logic        lastIter;

  // Booth step: the add/subtract is done one bit wider so the sign shifted into
  // the accumulator stays correct when the multiplicand is -2^31.
  always_comb begin
    boothSum = {acc_q[31], acc_q};
    case ({quo_q[0], q1_q})
      2'b01:   boothSum = {acc_q[31], acc_q} + {opm_q[31], opm_q};
      2'b10:   boothSum = {acc_q[31], acc_q} - {opm_q[31], opm_q};
      default: boothSum = {acc_q[31], acc_q};
    endcase
    boothAcc = boothSum[32:1];
    boothQuo = {boothSum[0], quo_q[31:1]};
  end

  // Restoring step: the partial remainder is always below the divisor (<= 2^31),
  // so its top bit is zero and the shifted value fits in 32 bits.
  always_comb begin
    remShift = {acc_q[30:0], quo_q[31]};
    remDiff  = {1'b0, remShift} - {1'b0, opm_q};
    divOk    = ~remDiff[32];
    divAcc   = divOk ? remDiff[31:0] : remShift;
    divQuo   = {quo_q[30:0], divOk};
  end

  always_comb begin
    absA     = a[31] ? (~a + 32'd1) : a;
    absB     = b[31] ? (~b + 32'd1) : b;
    cntNext  = cnt_q + 6'd1;
    lastIter = (cntNext == 6'd32);
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    q1_d      = q1_q;
    opm_d     = opm_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    divZero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mult_start) begin
          state_d = MULT;
          acc_d   = 32'd0;
          quo_d   = b;
          q1_d    = 1'b0;
          opm_d   = a;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
        end else if (div_start) begin
          if (b == 32'd0) begin
            state_d   = DONE;
            done_d    = 1'b1;
            divZero_d = 1'b1;
          end else begin
            state_d   = DIV;
            acc_d     = 32'd0;
            quo_d     = absA;
            q1_d      = 1'b0;
            opm_d     = absB;
            negQuot_d = a[31] ^ b[31];
            negRem_d  = a[31];
            cnt_d     = 6'd0;
            busy_d    = 1'b1;
          end
        end
      end

      MULT: begin
        acc_d = boothAcc;
        quo_d = boothQuo;
        q1_d  = quo_q[0];
        cnt_d = cntNext;
        if (lastIter) begin
          state_d = DONE;
          hi_d    = boothAcc;
          lo_d    = boothQuo;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      DIV: begin
        acc_d = divAcc;
        quo_d = divQuo;
        cnt_d = cntNext;
        if (lastIter) begin
          state_d = DONE;
          hi_d    = negRem_q ? (~divAcc + 32'd1) : divAcc;
          lo_d    = negQuot_q ? (~divQuo + 32'd1) : divQuo;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 32'd0;
      quo_q     <= 32'd0;
      q1_q      <= 1'b0;
      opm_q     <= 32'd0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      cnt_q     <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      q1_q      <= q1_d;
      opm_q     <= opm_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, start/reset ordering,
// and randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Expected results from plain signed arithmetic; a rejected divide leaves HI/LO as they were.
  task automatic referenceModel(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] eHi, output logic [31:0] eLo, output logic eZero);
    longint sa, sb, prod, quo, rem;
    sa    = longint'($signed(av));
    sb    = longint'($signed(bv));
    eZero = 1'b0;
    eHi   = modelHi;
    eLo   = modelLo;
    if (m) begin
      prod = sa * sb;
      eHi  = prod[63:32];
      eLo  = prod[31:0];
    end else if (d) begin
      if (sb == 0) begin
        eZero = 1'b1;
      end else begin
        quo = sa / sb;
        rem = sa % sb;
        eHi = rem[31:0];
        eLo = quo[31:0];
      end
    end
  endtask

  // Issues one start and checks the full cycle-by-cycle response. intrAt >= 0 injects a
  // competing mult_start sampled at edge N+intrAt+1 and another start during DONE.
  task automatic applyStimulus(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                               input int intrAt, input string tag);
    logic [31:0] eHi, eLo;
    logic        eZero;
    referenceModel(m, d, av, bv, eHi, eLo, eZero);

    @(negedge clk);
    mult_start = m;
    div_start  = d;
    a          = av;
    b          = bv;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = $urandom;
    b          = $urandom;

    if (eZero) begin
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " div_zero"}, 32'(div_zero), 32'd1);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " hi kept"}, hi, modelHi);
      checkOutput({tag, " lo kept"}, lo, modelLo);
      @(negedge clk);
      checkOutput({tag, " done drop"}, 32'(done), 32'd0);
      checkOutput({tag, " div_zero drop"}, 32'(div_zero), 32'd0);
      checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    end else begin
      for (int k = 0; k < 32; k++) begin
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " early done"}, 32'(done), 32'd0);
        if (intrAt >= 0 && k == intrAt) begin
          mult_start = 1'b1;
          a          = $urandom;
          b          = $urandom;
        end
        if (intrAt >= 0 && k == intrAt + 1) mult_start = 1'b0;
        @(negedge clk);
      end
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
      checkOutput({tag, " div_zero"}, 32'(div_zero), 32'd0);
      checkOutput({tag, " hi"}, hi, eHi);
      checkOutput({tag, " lo"}, lo, eLo);
      modelHi = eHi;
      modelLo = eLo;
      if (intrAt >= 0) begin
        mult_start = 1'b1;
        div_start  = 1'b1;
        a          = $urandom;
        b          = $urandom;
      end
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      checkOutput({tag, " done drop"}, 32'(done), 32'd0);
      checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
      if (intrAt >= 0) begin
        @(negedge clk);
        checkOutput({tag, " no queued start"}, 32'(busy), 32'd0);
        checkOutput({tag, " hi hold"}, hi, eHi);
        checkOutput({tag, " lo hold"}, lo, eLo);
      end
    end
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 20);
      4:       v = -($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic        m, d;
    logic [31:0] av, bv;

    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    modelHi    = 32'd0;
    modelLo    = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset div_zero", 32'(div_zero), 32'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'd7, -32'sd3, -1, "mul 7*-3");
    checkOutput("mul 7*-3 hi const", hi, 32'hFFFF_FFFF);
    checkOutput("mul 7*-3 lo const", lo, 32'hFFFF_FFEB);
    applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, "mul max*max");
    checkOutput("mul max hi const", hi, 32'h3FFF_FFFF);
    checkOutput("mul max lo const", lo, 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, "mul min*min");
    checkOutput("mul min hi const", hi, 32'h4000_0000);
    checkOutput("mul min lo const", lo, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, -32'sd7, 32'd2, -1, "div -7/2");
    checkOutput("div -7/2 lo const", lo, 32'hFFFF_FFFD);
    checkOutput("div -7/2 hi const", hi, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 32'd7, -32'sd2, -1, "div 7/-2");
    checkOutput("div 7/-2 lo const", lo, 32'hFFFF_FFFD);
    checkOutput("div 7/-2 hi const", hi, 32'h0000_0001);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div min/-1");
    checkOutput("div min/-1 lo const", lo, 32'h8000_0000);
    checkOutput("div min/-1 hi const", hi, 32'h0000_0000);

    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h0BAD_F00D, -1, "preload mul");
    applyStimulus(1'b0, 1'b1, 32'd99, 32'd0, -1, "div by zero");

    applyStimulus(1'b1, 1'b1, 32'd12, 32'd5, -1, "both starts");
    applyStimulus(1'b1, 1'b1, 32'd12, 32'd0, -1, "both starts b0");
    applyStimulus(1'b1, 1'b0, -32'sd1234, 32'd4321, 9, "start at N+10");

    // Abort a multiply partway through with an asynchronous reset.
    @(negedge clk);
    mult_start = 1'b1;
    a          = 32'd1000;
    b          = 32'd3000;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    modelHi = 32'd0;
    modelLo = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checkOutput("post-abort done", 32'(done), 32'd0);
      checkOutput("post-abort busy", 32'(busy), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd7, -1, "after abort");

    for (int n = 0; n < 40; n++) begin
      m  = 1'b0;
      d  = 1'b0;
      case ($urandom_range(0, 4))
        0, 1:    m = 1'b1;
        2, 3:    d = 1'b1;
        default: begin m = 1'b1; d = 1'b1; end
      endcase
      av = pickOperand();
      bv = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand();
      applyStimulus(m, d, av, bv, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
